// File: rtl/mc_native_pkg.sv
// Shared widths and payload layouts for the controller native ports.
package mc_native_pkg;
   localparam int ADDR_W = 25;
   localparam int DATA_W = 256;
   localparam int MASK_W = DATA_W / 8;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
   } native_cmd_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] we;
   } native_wdata_t;
endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO; a push is visible at the head one cycle later.
// Push while full is ignored even if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
   assign w_pop   = i_pop && (r_count != '0);
   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/native_port_buffer.sv
// Per-port buffer in front of a controller native port: command, write-data and
// read-return FIFOs, read credit accounting and write-after-data issue gating.
module native_port_buffer #(
   parameter int ADDR_W    = mc_native_pkg::ADDR_W,
   parameter int DATA_W    = mc_native_pkg::DATA_W,
   parameter int MASK_W    = DATA_W / 8,
   parameter int CMD_DEPTH = 4,
   parameter int RD_DEPTH  = 8,
   localparam int CRD_W    = $clog2(RD_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              u_cmd_valid,
   output logic              u_cmd_ready,
   input  logic              u_cmd_we,
   input  logic [ADDR_W-1:0] u_cmd_addr,
   input  logic              u_wdata_valid,
   output logic              u_wdata_ready,
   input  logic [DATA_W-1:0] u_wdata_data,
   input  logic [MASK_W-1:0] u_wdata_we,
   output logic              u_rdata_valid,
   input  logic              u_rdata_ready,
   output logic [DATA_W-1:0] u_rdata_data,
   output logic              n_cmd_valid,
   input  logic              n_cmd_ready,
   output logic              n_cmd_we,
   output logic [ADDR_W-1:0] n_cmd_addr,
   output logic              n_wdata_valid,
   input  logic              n_wdata_ready,
   output logic [DATA_W-1:0] n_wdata_data,
   output logic [MASK_W-1:0] n_wdata_we,
   input  logic              n_rdata_valid,
   input  logic [DATA_W-1:0] n_rdata_data,
   output logic              n_rdata_ready,
   output logic [CRD_W-1:0]  rd_credits_used,
   output logic              err_rd_overflow
);
   import mc_native_pkg::*;

   localparam int CMD_W = 1 + ADDR_W;
   localparam int WD_W  = DATA_W + MASK_W;
   localparam int CC_W  = $clog2(CMD_DEPTH + 1);
   localparam logic [CRD_W-1:0] RD_LIMIT  = CRD_W'(RD_DEPTH);
   localparam logic [CC_W-1:0]  CMD_LIMIT = CC_W'(CMD_DEPTH);

   logic [CC_W-1:0]  w_cmd_count;
   logic [CMD_W-1:0] w_cmd_head;
   logic [CC_W-1:0]  w_wd_count;
   logic [WD_W-1:0]  w_wd_head;
   logic [CRD_W-1:0] w_rd_count;
   logic             w_cmd_empty;
   logic             w_gate;
   logic             w_cmd_fire;
   logic             w_wd_fire;
   logic             w_rd_bad;
   logic             w_rd_push;
   logic             w_rd_pop;
   logic             w_rd_issue;
   logic [CRD_W-1:0] r_rd_inflight;
   logic [CC_W-1:0]  r_wr_issued;
   logic             r_err_rd_overflow;

   sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (u_cmd_valid && u_cmd_ready),
      .i_data  ({u_cmd_we, u_cmd_addr}),
      .i_pop   (w_cmd_fire),
      .o_data  (w_cmd_head),
      .o_count (w_cmd_count)
   );

   sync_fifo #(.WIDTH(WD_W), .DEPTH(CMD_DEPTH)) u_wd_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (u_wdata_valid && u_wdata_ready),
      .i_data  ({u_wdata_data, u_wdata_we}),
      .i_pop   (w_wd_fire),
      .o_data  (w_wd_head),
      .o_count (w_wd_count)
   );

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rd_push),
      .i_data  (n_rdata_data),
      .i_pop   (w_rd_pop),
      .o_data  (u_rdata_data),
      .o_count (w_rd_count)
   );

   assign u_cmd_ready   = (w_cmd_count != CMD_LIMIT);
   assign u_wdata_ready = (w_wd_count != CMD_LIMIT);
   assign w_cmd_empty   = (w_cmd_count == '0);
   assign n_cmd_we      = w_cmd_head[CMD_W-1];
   assign n_cmd_addr    = w_cmd_head[ADDR_W-1:0];
   assign n_wdata_data  = w_wd_head[WD_W-1:MASK_W];
   assign n_wdata_we    = w_wd_head[MASK_W-1:0];
   assign n_rdata_ready = 1'b1;

   // Credits cover both reads still at the controller and data parked for the user.
   assign rd_credits_used = r_rd_inflight + w_rd_count;

   // A write may only leave once buffered data exceeds the writes already owed data.
   assign w_gate      = n_cmd_we ? (w_wd_count > r_wr_issued) : (rd_credits_used < RD_LIMIT);
   assign n_cmd_valid = !w_cmd_empty && w_gate;
   assign w_cmd_fire  = n_cmd_valid && n_cmd_ready;
   assign w_rd_issue  = w_cmd_fire && !n_cmd_we;

   assign n_wdata_valid = (w_wd_count != '0) && (r_wr_issued != '0);
   assign w_wd_fire     = n_wdata_valid && n_wdata_ready;

   assign w_rd_bad  = n_rdata_valid && ((w_rd_count == RD_LIMIT) || (r_rd_inflight == '0));
   assign w_rd_push = n_rdata_valid && !w_rd_bad;

   assign u_rdata_valid   = (w_rd_count != '0);
   assign w_rd_pop        = u_rdata_valid && u_rdata_ready;
   assign err_rd_overflow = r_err_rd_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_inflight     <= '0;
         r_wr_issued       <= '0;
         r_err_rd_overflow <= 1'b0;
      end else begin
         case ({w_rd_issue, w_rd_push})
            2'b10:   if (r_rd_inflight != RD_LIMIT) r_rd_inflight <= r_rd_inflight + 1'b1;
            2'b01:   if (r_rd_inflight != '0)       r_rd_inflight <= r_rd_inflight - 1'b1;
            default: ;
         endcase
         case ({w_cmd_fire && n_cmd_we, w_wd_fire})
            2'b10:   if (r_wr_issued != CMD_LIMIT) r_wr_issued <= r_wr_issued + 1'b1;
            2'b01:   if (r_wr_issued != '0)        r_wr_issued <= r_wr_issued - 1'b1;
            default: ;
         endcase
         if (w_rd_bad) r_err_rd_overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_native_port_buffer.sv
// Bench for native_port_buffer: a per-cycle vector table, directed corner sequences
// and randomized traffic checked against a queue-based transaction model.
module tb_native_port_buffer;
   import mc_native_pkg::*;

   localparam int CRD_W = $clog2(8 + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              u_cmd_valid, u_cmd_ready, u_cmd_we;
   logic [ADDR_W-1:0] u_cmd_addr;
   logic              u_wdata_valid, u_wdata_ready;
   logic [DATA_W-1:0] u_wdata_data;
   logic [MASK_W-1:0] u_wdata_we;
   logic              u_rdata_valid, u_rdata_ready;
   logic [DATA_W-1:0] u_rdata_data;
   logic              n_cmd_valid, n_cmd_ready, n_cmd_we;
   logic [ADDR_W-1:0] n_cmd_addr;
   logic              n_wdata_valid, n_wdata_ready;
   logic [DATA_W-1:0] n_wdata_data;
   logic [MASK_W-1:0] n_wdata_we;
   logic              n_rdata_valid, n_rdata_ready;
   logic [DATA_W-1:0] n_rdata_data;
   logic [CRD_W-1:0]  rd_credits_used;
   logic              err_rd_overflow;

   int n_cmp = 0;
   int n_err = 0;

   native_cmd_t   src_cmd[$];
   native_wdata_t src_wd[$];

   native_port_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
                        .CMD_DEPTH(4), .RD_DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .u_cmd_valid(u_cmd_valid), .u_cmd_ready(u_cmd_ready), .u_cmd_we(u_cmd_we),
      .u_cmd_addr(u_cmd_addr),
      .u_wdata_valid(u_wdata_valid), .u_wdata_ready(u_wdata_ready),
      .u_wdata_data(u_wdata_data), .u_wdata_we(u_wdata_we),
      .u_rdata_valid(u_rdata_valid), .u_rdata_ready(u_rdata_ready), .u_rdata_data(u_rdata_data),
      .n_cmd_valid(n_cmd_valid), .n_cmd_ready(n_cmd_ready), .n_cmd_we(n_cmd_we),
      .n_cmd_addr(n_cmd_addr),
      .n_wdata_valid(n_wdata_valid), .n_wdata_ready(n_wdata_ready),
      .n_wdata_data(n_wdata_data), .n_wdata_we(n_wdata_we),
      .n_rdata_valid(n_rdata_valid), .n_rdata_data(n_rdata_data), .n_rdata_ready(n_rdata_ready),
      .rd_credits_used(rd_credits_used), .err_rd_overflow(err_rd_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic cv, cwe, wv, ncr, nwr;
      logic ncv, nwv, ucr;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic idle_inputs();
      u_cmd_valid = 0; u_cmd_we = 0; u_cmd_addr = '0;
      u_wdata_valid = 0; u_wdata_data = '0; u_wdata_we = '0;
      u_rdata_ready = 0; n_cmd_ready = 0; n_wdata_ready = 0;
      n_rdata_valid = 0; n_rdata_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ucr"}, u_cmd_ready, 1);
      chk({tag, "_uwr"}, u_wdata_ready, 1);
      chk({tag, "_urv"}, u_rdata_valid, 0);
      chk({tag, "_ncv"}, n_cmd_valid, 0);
      chk({tag, "_nwv"}, n_wdata_valid, 0);
      chk({tag, "_nrr"}, n_rdata_ready, 1);
      chk({tag, "_credits"}, rd_credits_used, 0);
      chk({tag, "_err"}, err_rd_overflow, 0);
   endtask

   // Transaction-level model: the native side must see user commands and write data
   // in push order, read data must reach the user in return order, and credits equal
   // native reads issued minus reads consumed by the user.
   task automatic run_traffic(input string tag, input int budget, output int n_cmds, output int n_pops);
      native_cmd_t   exp_cmd[$];
      native_wdata_t exp_wd[$];
      native_cmd_t   c;
      native_wdata_t w;
      logic [255:0]  ret_q[$];
      int rd_iss = 0, rd_ret = 0, rd_pop = 0, wr_iss = 0, wd_taken = 0, cyc = 0;
      bit done = 0;
      n_cmds = 0;
      while (!done) begin
         u_cmd_valid = (src_cmd.size() > 0) && ($urandom_range(0, 2) != 0);
         if (src_cmd.size() > 0) begin
            u_cmd_we = src_cmd[0].we;
            u_cmd_addr = src_cmd[0].addr;
         end
         u_wdata_valid = (src_wd.size() > 0) && ($urandom_range(0, 2) != 0);
         if (src_wd.size() > 0) begin
            u_wdata_data = src_wd[0].data;
            u_wdata_we = src_wd[0].we;
         end
         n_cmd_ready = 1'($urandom_range(0, 1));
         n_wdata_ready = 1'($urandom_range(0, 1));
         u_rdata_ready = 1'($urandom_range(0, 1));
         n_rdata_valid = (rd_iss > rd_ret) && ($urandom_range(0, 2) == 0);
         n_rdata_data = rand256();
         #1;
         chk({tag, "_credits"}, rd_credits_used, rd_iss - rd_pop);
         if (u_rdata_valid && u_rdata_ready) begin
            if (ret_q.size() == 0) chk({tag, "_urdata_unexpected"}, 1, 0);
            else chk({tag, "_urdata"}, u_rdata_data, ret_q.pop_front());
            rd_pop++;
         end
         if (n_wdata_valid && n_wdata_ready) begin
            chk({tag, "_wd_after_cmd"}, wd_taken < wr_iss, 1);
            if (exp_wd.size() == 0) chk({tag, "_nwdata_unexpected"}, 1, 0);
            else begin
               w = exp_wd.pop_front();
               chk({tag, "_nwdata"}, {n_wdata_data, n_wdata_we}, w);
            end
            wd_taken++;
         end
         if (n_cmd_valid && n_cmd_ready) begin
            if (exp_cmd.size() == 0) chk({tag, "_ncmd_unexpected"}, 1, 0);
            else begin
               c = exp_cmd.pop_front();
               chk({tag, "_ncmd"}, {n_cmd_we, n_cmd_addr}, c);
            end
            if (n_cmd_we) wr_iss++;
            else rd_iss++;
            n_cmds++;
         end
         if (n_rdata_valid) begin
            ret_q.push_back(n_rdata_data);
            rd_ret++;
         end
         if (u_cmd_valid && u_cmd_ready) exp_cmd.push_back(src_cmd.pop_front());
         if (u_wdata_valid && u_wdata_ready) exp_wd.push_back(src_wd.pop_front());
         done = (src_cmd.size() == 0) && (exp_cmd.size() == 0) && (src_wd.size() == 0) &&
                (exp_wd.size() == 0) && (rd_ret == rd_iss) && (ret_q.size() == 0);
         tick();
         cyc++;
         if (!done && cyc > budget) begin
            chk({tag, "_timeout"}, 1, 0);
            done = 1;
         end
      end
      n_pops = rd_pop;
      idle_inputs();
      #1;
   endtask

   initial begin
      int pushed, issued, ncmds, npops;
      logic [255:0] d;
      native_cmd_t c;
      native_wdata_t w;

      idle_inputs();
      rst = 1;
      #2;
      chk_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // write gating: command at row 0, data at row 5, command may issue from row 6
      tbl[0]  = '{1, 1, 0, 1, 1, 0, 0, 1};
      tbl[1]  = '{0, 0, 0, 1, 1, 0, 0, 1};
      tbl[2]  = '{0, 0, 0, 1, 1, 0, 0, 1};
      tbl[3]  = '{0, 0, 0, 1, 1, 0, 0, 1};
      tbl[4]  = '{0, 0, 0, 1, 1, 0, 0, 1};
      tbl[5]  = '{0, 0, 1, 0, 1, 0, 0, 1};
      tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 1};
      tbl[7]  = '{0, 0, 0, 0, 1, 1, 0, 1};
      tbl[8]  = '{0, 0, 0, 1, 0, 1, 0, 1};
      tbl[9]  = '{0, 0, 0, 1, 0, 0, 1, 1};
      tbl[10] = '{0, 0, 0, 1, 1, 0, 1, 1};
      tbl[11] = '{0, 0, 0, 1, 1, 0, 0, 1};
      u_wdata_data = '1;
      u_wdata_we = 32'h0F0F_0F0F;
      for (int i = 0; i < 12; i++) begin
         u_cmd_valid = tbl[i].cv; u_cmd_we = tbl[i].cwe; u_cmd_addr = 25'h20;
         u_wdata_valid = tbl[i].wv; n_cmd_ready = tbl[i].ncr; n_wdata_ready = tbl[i].nwr;
         #1;
         chk($sformatf("tbl%0d_ncv", i), n_cmd_valid, tbl[i].ncv);
         chk($sformatf("tbl%0d_nwv", i), n_wdata_valid, tbl[i].nwv);
         chk($sformatf("tbl%0d_ucr", i), u_cmd_ready, tbl[i].ucr);
         if (tbl[i].ncv) chk($sformatf("tbl%0d_ncmd", i), {n_cmd_we, n_cmd_addr}, {1'b1, 25'h20});
         if (tbl[i].nwv) begin
            chk($sformatf("tbl%0d_wdata", i), n_wdata_data, {256{1'b1}});
            chk($sformatf("tbl%0d_wmask", i), n_wdata_we, 32'h0F0F_0F0F);
         end
         tick();
      end

      // ordering: R(0x10), W(0x20), R(0x30)
      do_reset();
      c.we = 0; c.addr = 25'h10; src_cmd.push_back(c);
      c.we = 1; c.addr = 25'h20; src_cmd.push_back(c);
      c.we = 0; c.addr = 25'h30; src_cmd.push_back(c);
      w.data = rand256(); w.we = $urandom; src_wd.push_back(w);
      run_traffic("ord", 500, ncmds, npops);
      chk("ord_ncmds", ncmds, 3);
      chk("ord_pops", npops, 2);

      // randomized mixed traffic
      do_reset();
      for (int i = 0; i < 300; i++) begin
         c.we = 1'($urandom_range(0, 1));
         c.addr = 25'($urandom);
         src_cmd.push_back(c);
         if (c.we) begin
            w.data = rand256(); w.we = $urandom;
            src_wd.push_back(w);
         end
      end
      run_traffic("rnd", 20000, ncmds, npops);
      chk("rnd_ncmds", ncmds, 300);
      chk("rnd_err", err_rd_overflow, 0);
      chk("rnd_credits_end", rd_credits_used, 0);

      // read credit limit
      do_reset();
      n_cmd_ready = 1;
      pushed = 0; issued = 0;
      for (int i = 0; i < 30; i++) begin
         u_cmd_valid = (pushed < 10); u_cmd_we = 0; u_cmd_addr = 25'(pushed + 'h100);
         #1;
         if (u_cmd_valid && u_cmd_ready) pushed++;
         if (n_cmd_valid && n_cmd_ready) issued++;
         tick();
      end
      u_cmd_valid = 0;
      #1;
      chk("crd_issued", issued, 8);
      chk("crd_used", rd_credits_used, 8);
      chk("crd_gate", n_cmd_valid, 0);
      chk("crd_head", {n_cmd_we, n_cmd_addr}, {1'b0, 25'h108});
      d = rand256();
      n_rdata_valid = 1; n_rdata_data = d;
      #1;
      chk("crd_urv_same_cycle", u_rdata_valid, 0);
      tick();
      n_rdata_valid = 0; u_rdata_ready = 1;
      #1;
      chk("crd_urv_next", u_rdata_valid, 1);
      chk("crd_urdata", u_rdata_data, d);
      chk("crd_used_after_ret", rd_credits_used, 8);
      chk("crd_gate_before_pop", n_cmd_valid, 0);
      tick();
      u_rdata_ready = 0;
      #1;
      chk("crd_used_after_pop", rd_credits_used, 7);
      chk("crd_ninth_issue", n_cmd_valid, 1);
      tick();

      // full command FIFO back-pressure
      do_reset();
      n_cmd_ready = 0;
      for (int i = 0; i < 4; i++) begin
         u_cmd_valid = 1; u_cmd_we = 0; u_cmd_addr = 25'(i);
         tick();
      end
      u_cmd_valid = 0;
      #1;
      chk("bp_full_ucr", u_cmd_ready, 0);
      chk("bp_full_ncv", n_cmd_valid, 1);
      n_cmd_ready = 1; u_cmd_valid = 1; u_cmd_addr = 25'h1AB;
      #1;
      chk("bp_pop_cycle_ucr", u_cmd_ready, 0);
      tick();
      n_cmd_ready = 0; u_cmd_valid = 0;
      #1;
      chk("bp_after_pop_ucr", u_cmd_ready, 1);
      chk("bp_head", n_cmd_addr, 1);

      // overflow with nothing in flight
      do_reset();
      n_rdata_valid = 1; n_rdata_data = rand256();
      tick();
      n_rdata_valid = 0;
      #1;
      chk("ovf_err", err_rd_overflow, 1);
      chk("ovf_urv", u_rdata_valid, 0);
      chk("ovf_credits", rd_credits_used, 0);
      repeat (3) tick();
      chk("ovf_err_held", err_rd_overflow, 1);
      chk("ovf_urv_held", u_rdata_valid, 0);

      // async reset in the middle of a read burst
      do_reset();
      n_cmd_ready = 1;
      for (int i = 0; i < 4; i++) begin
         u_cmd_valid = 1; u_cmd_we = 0; u_cmd_addr = 25'(i + 'h40);
         tick();
      end
      u_cmd_valid = 0;
      #1;
      chk("arst_credits_busy", rd_credits_used != 0, 1);
      #2;
      rst = 1;
      #1;
      chk_reset_outputs("arst");
      tick();
      rst = 0;
      #1;
      chk("arst_credits_rel", rd_credits_used, 0);
      chk("arst_ucr_rel", u_cmd_ready, 1);
      n_rdata_valid = 1;
      tick();
      n_rdata_valid = 0;
      #1;
      chk("arst_late_return_err", err_rd_overflow, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
